mesh_result_serializer: RTL and testbench

//   Host-side drain stage downstream of the real-cores mesh wrapper's output FIFO.

---
 rtl/mesh_result_serializer.sv | 121 ++++++++++++
 tb/tb_mesh_result_serializer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_result_serializer.sv
// Drains result words from the mesh wrapper FIFO with one-word read pulses
// and streams each word MSB byte first over a valid/ready byte port.
module mesh_result_serializer #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clock,
  input  logic                  RST,
  input  logic                  enable,
  output logic                  cmd,
  input  logic [DATA_WIDTH-1:0] mesh_data,
  input  logic                  mesh_valid,
  output logic [7:0]            byte_data,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  timeout_err,
  output logic                  drop_err,
  output logic                  busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   drop_q, drop_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    count_d     = count_q;
    drop_d      = drop_q;
    cmd         = 1'b0;
    byte_valid  = 1'b0;
    timeout_err = 1'b0;

    // Only a word arriving in WAIT was asked for; anything else is lost.
    if (mesh_valid && (state_q != S_WAIT)) begin
      drop_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cmd     = 1'b1;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mesh_valid) begin
          shift_d = mesh_data;
          idx_d   = '0;
          state_d = S_SEND;
        end else if (timer_q == T_LAST) begin
          timeout_err = 1'b1;
          state_d     = enable ? S_REQ : S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SEND: begin
        byte_valid = 1'b1;
        if (byte_ready) begin
          shift_d = shift_q << 8;
          idx_d   = idx_q + 1'b1;
          if (idx_q == I_LAST) begin
            count_d = count_q + 1'b1;
            state_d = enable ? S_REQ : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign byte_data  = (state_q == S_SEND) ?
                      shift_q[DATA_WIDTH-1 -: 8] : 8'h00;
  assign busy       = (state_q != S_IDLE);
  assign word_count = count_q;
  assign drop_err   = drop_q;

  always_ff @(posedge clock) begin
    if (!RST) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_mesh_result_serializer.sv
// Bench for mesh_result_serializer: vector table, corner sequences and a
// randomized run against a byte-queue reference model.
module tb_mesh_result_serializer;

  logic        clock = 1'b0;
  logic        RST;
  logic        enable;
  logic        mesh_valid;
  logic [31:0] mesh_data;
  logic        byte_ready;

  logic        cmd, byte_valid, timeout_err, drop_err, busy;
  logic [7:0]  byte_data;
  logic [15:0] word_count;

  logic        cmd2, byte_valid2, timeout_err2, drop_err2, busy2;
  logic [7:0]  byte_data2;
  logic [1:0]  word_count2;

  mesh_result_serializer dut (
    .clock(clock), .RST(RST), .enable(enable), .cmd(cmd),
    .mesh_data(mesh_data), .mesh_valid(mesh_valid),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .word_count(word_count),
    .timeout_err(timeout_err), .drop_err(drop_err), .busy(busy)
  );

  mesh_result_serializer #(.CNT_WIDTH(2)) dut2 (
    .clock(clock), .RST(RST), .enable(enable), .cmd(cmd2),
    .mesh_data(mesh_data), .mesh_valid(mesh_valid),
    .byte_data(byte_data2), .byte_valid(byte_valid2),
    .byte_ready(byte_ready), .word_count(word_count2),
    .timeout_err(timeout_err2), .drop_err(drop_err2), .busy(busy2)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Observer: records handshakes and events with their cycle numbers
  int         cyc_n = 0;
  logic [7:0] got_b[$];
  int         got_c[$];
  int         cmd_c[$];
  int         to_c[$];
  int         mv_c[$];
  int         nbv = 0;
  int         cmd2x = 0;
  int         stall_bad = 0;
  logic       prev_cmd = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_b = 8'h00;

  always @(negedge clock) begin
    cyc_n <= cyc_n + 1;
    if (RST) begin
      if (byte_valid) nbv <= nbv + 1;
      if (byte_valid && byte_ready) begin
        got_b.push_back(byte_data);
        got_c.push_back(cyc_n);
      end
      if (cmd) cmd_c.push_back(cyc_n);
      if (cmd && prev_cmd) cmd2x <= cmd2x + 1;
      if (timeout_err) to_c.push_back(cyc_n);
      if (mesh_valid) mv_c.push_back(cyc_n);
      if (prev_stall && byte_valid && byte_data != prev_b)
        stall_bad <= stall_bad + 1;
    end
    prev_cmd   <= RST & cmd;
    prev_stall <= RST & byte_valid & ~byte_ready;
    prev_b     <= byte_data;
  end

  // Wrapper FIFO model and consumer
  int          pend = -1;
  logic [31:0] pend_d;
  logic [31:0] resp_q[$];
  int          resp_lat = 2;
  logic        inj = 1'b0;
  logic [31:0] inj_d;
  int          rdy_mode = 0;
  bit          rdy_pat[$];
  bit          rand_on = 1'b0;
  int          skip_n, nresp;
  logic [7:0]  exp_b[$];

  task automatic cyc();
    @(posedge clock);
    #1;
    mesh_valid = 1'b0;
    mesh_data  = $urandom;
    if (pend > 0) pend--;
    if (pend == 0) begin
      mesh_valid = 1'b1;
      mesh_data  = pend_d;
      pend       = -1;
    end
    if (inj) begin
      mesh_valid = 1'b1;
      mesh_data  = inj_d;
      inj        = 1'b0;
    end
    if (cmd && RST) begin
      if (rand_on) begin
        if ($urandom_range(4) == 0) begin
          skip_n++;
        end else begin
          pend   = int'($urandom_range(3, 2));
          pend_d = $urandom;
          nresp++;
          for (int k = 0; k < 4; k++)
            exp_b.push_back(pend_d[31-8*k -: 8]);
        end
      end else if (resp_q.size() > 0) begin
        pend   = resp_lat;
        pend_d = resp_q.pop_front();
      end
    end
    case (rdy_mode)
      1: byte_ready = (byte_valid && rdy_pat.size() > 0) ?
                      rdy_pat.pop_front() : 1'b1;
      2: byte_ready = 1'($urandom_range(1));
      default: byte_ready = 1'b1;
    endcase
    if (rand_on) enable = ($urandom_range(7) != 0);
  endtask

  task automatic do_reset();
    RST      = 1'b0;
    enable   = 1'b0;
    pend     = -1;
    inj      = 1'b0;
    rand_on  = 1'b0;
    rdy_mode = 0;
    resp_lat = 2;
    resp_q.delete();
    rdy_pat.delete();
    repeat (3) cyc();
    RST = 1'b1;
  endtask

  task automatic run_bytes(int base, int n, int budget, string nm);
    int i = 0;
    while (got_b.size() - base < n && i < budget) begin
      cyc();
      i++;
    end
    chk(nm, got_b.size() - base, n);
  endtask

  function automatic logic [31:0] word_at(int base);
    return {got_b[base], got_b[base+1], got_b[base+2], got_b[base+3]};
  endfunction

  typedef struct {
    logic [31:0] word;
    int          lat;
    int          npat;
    logic [7:0]  pat;
    logic [31:0] exp;
    bit          lat_chk;
  } vec_t;

  vec_t       vt[5];
  logic [7:0] e6[8];

  initial begin
    int base, sb, mvb, cb, tb0, nb0, i;

    vt[0] = '{32'hDEADBEEF, 2, 0, 8'h00, 32'hDEADBEEF, 1'b1};
    vt[1] = '{32'hDEADBEEF, 2, 7, 8'h69, 32'hDEADBEEF, 1'b0};
    vt[2] = '{32'h01020304, 3, 6, 8'h36, 32'h01020304, 1'b0};
    vt[3] = '{32'hA0B0C0D0, 2, 7, 8'h78, 32'hA0B0C0D0, 1'b0};
    vt[4] = '{32'h0000FF80, 3, 0, 8'h00, 32'h0000FF80, 1'b1};
    e6 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0};

    RST = 1'b0; enable = 1'b0; mesh_valid = 1'b0;
    mesh_data = '0; byte_ready = 1'b1;

    // Reset held with enable high: everything stays quiet
    do_reset();
    RST = 1'b0;
    enable = 1'b1;
    repeat (3) cyc();
    chk("rst_cmd", cmd, 0);
    chk("rst_bdata", byte_data, 0);
    chk("rst_bvalid", byte_valid, 0);
    chk("rst_wcount", word_count, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_busy", busy, 0);

    foreach (vt[v]) begin
      do_reset();
      rdy_mode = 1;
      for (int j = 0; j < vt[v].npat; j++) rdy_pat.push_back(vt[v].pat[j]);
      resp_lat = vt[v].lat;
      resp_q.push_back(vt[v].word);
      base = got_b.size();
      sb   = stall_bad;
      mvb  = mv_c.size();
      enable = 1'b1;
      run_bytes(base, 4, 40, $sformatf("v%0d_len", v));
      if (got_b.size() >= base + 4) begin
        for (int k = 0; k < 4; k++)
          chk($sformatf("v%0d_b%0d", v, k), got_b[base+k],
              vt[v].exp[31-8*k -: 8]);
        if (vt[v].lat_chk) begin
          chk($sformatf("v%0d_lat", v), got_c[base] - mv_c[mvb], 1);
          chk($sformatf("v%0d_burst", v), got_c[base+3] - got_c[base], 3);
        end
      end
      chk($sformatf("v%0d_nextcmd", v), cmd, 1);
      chk($sformatf("v%0d_bvdrop", v), byte_valid, 0);
      chk($sformatf("v%0d_wcount", v), word_count, 1);
      chk($sformatf("v%0d_stall", v), stall_bad - sb, 0);
    end

    // No data returned: timeout pulse 8 cycles after cmd, then retry
    do_reset();
    cb = cmd_c.size(); tb0 = to_c.size(); nb0 = nbv;
    enable = 1'b1;
    i = 0;
    while (to_c.size() == tb0 && i < 30) begin cyc(); i++; end
    chk("to_seen", to_c.size() - tb0, 1);
    if (to_c.size() > tb0 && cmd_c.size() > cb)
      chk("to_delay", to_c[tb0] - cmd_c[cb], 8);
    i = 0;
    while (cmd_c.size() < cb + 2 && i < 6) begin cyc(); i++; end
    chk("to_recmd", cmd_c.size() - cb, 2);
    if (cmd_c.size() >= cb + 2 && to_c.size() > tb0)
      chk("to_recmd_gap", cmd_c[cb+1] - to_c[tb0], 1);
    chk("to_width", to_c.size() - tb0, 1);
    chk("to_wcount", word_count, 0);
    chk("to_nobyte", nbv - nb0, 0);

    // Unsolicited data while idle
    do_reset();
    nb0 = nbv;
    repeat (2) cyc();
    inj = 1'b1;
    inj_d = 32'h12345678;
    cyc();
    cyc();
    chk("drop_set", drop_err, 1);
    chk("drop_busy", busy, 0);
    repeat (5) cyc();
    chk("drop_hold", drop_err, 1);
    chk("drop_nobyte", nbv - nb0, 0);
    chk("drop_wcount", word_count, 0);
    resp_q.push_back(32'h55AA33CC);
    base = got_b.size();
    enable = 1'b1;
    run_bytes(base, 4, 40, "drop_len");
    if (got_b.size() >= base + 4)
      chk("drop_word", word_at(base), 32'h55AA33CC);
    chk("drop_sticky", drop_err, 1);

    // Reset in the middle of a word
    do_reset();
    resp_q.push_back(32'hDEADBEEF);
    base = got_b.size();
    enable = 1'b1;
    run_bytes(base, 2, 40, "mid_len");
    chk("mid_pre_bv", byte_valid, 1);
    RST = 1'b0;
    cyc();
    chk("mid_bv", byte_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_wcount", word_count, 0);
    RST = 1'b1;
    resp_q.push_back(32'hCAFEF00D);
    base = got_b.size();
    run_bytes(base, 4, 40, "mid_len2");
    if (got_b.size() >= base + 4)
      chk("mid_word", word_at(base), 32'hCAFEF00D);
    chk("mid_wcount2", word_count, 1);

    // Back-to-back words, enable dropped during the second
    do_reset();
    resp_q.push_back(32'h01020304);
    resp_q.push_back(32'hA0B0C0D0);
    resp_lat = 3;
    cb = cmd_c.size();
    base = got_b.size();
    enable = 1'b1;
    i = 0;
    while (got_b.size() - base < 8 && i < 60) begin
      cyc();
      if (got_b.size() - base >= 5) enable = 1'b0;
      i++;
    end
    repeat (4) cyc();
    chk("b2b_len", got_b.size() - base, 8);
    if (got_b.size() >= base + 8)
      for (int k = 0; k < 8; k++)
        chk($sformatf("b2b_b%0d", k), got_b[base+k], e6[k]);
    chk("b2b_cmds", cmd_c.size() - cb, 2);
    chk("b2b_wcount", word_count, 2);
    chk("b2b_idle", busy, 0);

    // Narrow counter wraps after four words
    do_reset();
    for (int k = 0; k < 5; k++) resp_q.push_back(32'h11111111 * (k + 1));
    base = got_b.size();
    enable = 1'b1;
    i = 0;
    while (got_b.size() - base < 20 && i < 150) begin
      cyc();
      if (got_b.size() - base >= 17) enable = 1'b0;
      i++;
    end
    repeat (4) cyc();
    chk("wrap_len", got_b.size() - base, 20);
    chk("wrap_wc2", word_count2, 1);
    chk("wrap_wc16", word_count, 5);

    // Randomized run against the byte-queue model
    do_reset();
    skip_n = 0;
    nresp  = 0;
    exp_b.delete();
    base = got_b.size();
    tb0  = to_c.size();
    sb   = stall_bad;
    rdy_mode = 2;
    rand_on  = 1'b1;
    repeat (600) cyc();
    rand_on  = 1'b0;
    enable   = 1'b0;
    rdy_mode = 0;
    i = 0;
    while ((busy || pend != -1) && i < 100) begin cyc(); i++; end
    cyc();
    chk("rnd_drain", busy, 0);
    chk("rnd_len", got_b.size() - base, exp_b.size());
    begin
      int mm = 0;
      for (int k = 0; k < exp_b.size() && base + k < got_b.size(); k++)
        if (got_b[base+k] !== exp_b[k]) mm++;
      chk("rnd_bytes_mismatched", mm, 0);
    end
    chk("rnd_wcount", word_count, nresp & 16'hFFFF);
    chk("rnd_wc2", word_count2, nresp % 4);
    chk("rnd_timeouts", to_c.size() - tb0, skip_n);
    chk("rnd_drop", drop_err, 0);
    chk("rnd_stall", stall_bad - sb, 0);
    chk("cmd_single_cycle", cmd2x, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
